// File: rtl/out_ctrl.sv
// Stochastic bitstream decoder: counts ones over a 2^N-sample window and returns the count over valid/ready.
// Build option BIPOLAR_EN: result becomes signed 2*ones - 2^N, saturated to the OW-bit range.
module out_ctrl #(
    parameter int N  = 12,
    parameter int OW = N + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid and result stay stable while out_ready is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [N:0] LAST_IDX = (N+1)'((1 << N) - 1);

    state_t        r_state;
    logic [N:0]    r_samples;
    logic [N:0]    r_ones;
    logic [OW-1:0] r_result;

    logic          w_accept;
    logic          w_last;
    logic [N:0]    w_ones_next;
    logic [OW-1:0] w_result;

    assign w_accept    = in_valid && (r_state == S_COUNT);
    assign w_last      = w_accept && (r_samples == LAST_IDX);
    assign w_ones_next = r_ones + {{N{1'b0}}, in_bit};

`ifdef BIPOLAR_EN
    localparam logic [N+1:0] FULL_SCALE = (N+2)'(1 << N);
    logic [N+1:0] w_bip;

    assign w_bip = {w_ones_next, 1'b0} - FULL_SCALE;
    // Only the all-ones window can overflow the positive side; negative side always fits.
    assign w_result = (!w_bip[N+1] && w_bip[N]) ? OW'((1 << N) - 1) : OW'(w_bip[N:0]);
`else
    assign w_result = OW'(w_ones_next);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_samples <= '0;
            r_ones    <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_COUNT;
                        r_samples <= '0;
                        r_ones    <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_samples <= r_samples + 1'b1;
                        r_ones    <= w_ones_next;
                        if (w_last) begin
                            r_result <= w_result;
                            r_state  <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (start) begin
                            r_state   <= S_COUNT;
                            r_samples <= '0;
                            r_ones    <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_COUNT);
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_out_ctrl.sv
// Directed bench for out_ctrl: an N=4 instance for window/handshake cases and an N=12 instance
// for the full-length window. Expected results are queued at stimulus time and popped on handshake.
module tb_out_ctrl;

`ifdef BIPOLAR_EN
    localparam logic [4:0]  A_ALL1 = 5'd15;
    localparam logic [4:0]  A_ALL0 = 5'h10;
    localparam logic [4:0]  A_GAP  = 5'd15;
    localparam logic [4:0]  A_HALF = 5'd0;
    localparam logic [4:0]  A_12   = 5'd8;
    localparam logic [12:0] B_ALT  = 13'd0;
`else
    localparam logic [4:0]  A_ALL1 = 5'd16;
    localparam logic [4:0]  A_ALL0 = 5'd0;
    localparam logic [4:0]  A_GAP  = 5'd16;
    localparam logic [4:0]  A_HALF = 5'd8;
    localparam logic [4:0]  A_12   = 5'd12;
    localparam logic [12:0] B_ALT  = 13'd2048;
`endif

    logic clock = 1'b0;
    logic reset_n;

    logic        a_start, a_in_bit, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [4:0]  a_result;
    logic [1:0]  a_dbg;
    logic        b_start, b_in_bit, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [12:0] b_result;
    logic [1:0]  b_dbg;

    logic [4:0]  exp_a_q[$];
    logic [12:0] exp_b_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    out_ctrl #(.N(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .in_bit(a_in_bit),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .result(a_result),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy), .dbg_state(a_dbg)
    );

    out_ctrl #(.N(12)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .in_bit(b_in_bit),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .result(b_result),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy), .dbg_state(b_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clock) begin
        if (reset_n && a_out_valid && a_out_ready) begin
            if (exp_a_q.size() == 0) check("a_unexpected_output", 32'(a_result), 32'hFFFF_FFFF);
            else check("a_result", 32'(a_result), 32'(exp_a_q.pop_front()));
        end
        if (reset_n && b_out_valid && b_out_ready) begin
            if (exp_b_q.size() == 0) check("b_unexpected_output", 32'(b_result), 32'hFFFF_FFFF);
            else check("b_result", 32'(b_result), 32'(exp_b_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // Offers pattern bits until 16 are accepted; with gap set, every 3rd cycle has in_valid low.
    task automatic run_a(input logic [15:0] pattern, input bit gap, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        while (k < 16 && cycles < 200) begin
            a_in_valid = !(gap && (cycles % 3 == 2));
            a_in_bit   = pattern[k];
            if (a_in_valid && a_in_ready) k++;
            tick();
            cycles++;
        end
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;
    endtask

    task automatic wait_a_idle();
        int c;
        c = 0;
        while (a_busy && c < 50) begin
            tick();
            c++;
        end
        check("a_return_idle", 32'(a_busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        reset_n = 1'b0;
        {a_start, a_in_bit, a_in_valid, a_out_ready} = '0;
        {b_start, b_in_bit, b_in_valid, b_out_ready} = '0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            a_start    = 1'($urandom_range(0, 1));
            a_in_bit   = 1'($urandom_range(0, 1));
            a_in_valid = 1'($urandom_range(0, 1));
            b_start    = 1'($urandom_range(0, 1));
            b_in_valid = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("rst_in_ready", 32'(a_in_ready), 32'd0);
            check("rst_out_valid", 32'(a_out_valid), 32'd0);
            check("rst_result", 32'(a_result), 32'd0);
            check("rst_busy", 32'(a_busy), 32'd0);
        end
        check("rst_b_result", 32'(b_result), 32'd0);
        check("rst_dbg_state", 32'(a_dbg), 32'd0);
        {a_start, a_in_bit, a_in_valid} = '0;
        {b_start, b_in_bit, b_in_valid} = '0;
        tick();
        reset_n     = 1'b1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        tick();

        // samples offered in IDLE are dropped and do not start a window
        a_in_valid = 1'b1;
        a_in_bit   = 1'b1;
        tick();
        tick();
        check("idle_no_ready", 32'(a_in_ready), 32'd0);
        check("idle_not_busy", 32'(a_busy), 32'd0);
        a_in_valid = 1'b0;

        // 2: all ones then all zeros
        exp_a_q.push_back(A_ALL1);
        pulse_start_a();
        check("count_in_ready", 32'(a_in_ready), 32'd1);
        run_a(16'hFFFF, 1'b0, cyc);
        check("all1_cycles", 32'(cyc), 32'd16);
        check("all1_out_valid_next", 32'(a_out_valid), 32'd1);
        check("hold_dbg_state", 32'(a_dbg), 32'd2);
        wait_a_idle();

        exp_a_q.push_back(A_ALL0);
        pulse_start_a();
        run_a(16'h0000, 1'b0, cyc);
        check("all0_out_valid_next", 32'(a_out_valid), 32'd1);
        wait_a_idle();

        // 4: in_valid low every 3rd cycle; 16th acceptance needs 23 offered cycles
        exp_a_q.push_back(A_GAP);
        pulse_start_a();
        run_a(16'hFFFF, 1'b1, cyc);
        check("gap_cycles", 32'(cyc), 32'd23);
        check("gap_out_valid_next", 32'(a_out_valid), 32'd1);
        wait_a_idle();

        // 5: stall in HOLD with start pulses, then back-to-back restart on handshake
        a_out_ready = 1'b0;
        exp_a_q.push_back(A_HALF);
        pulse_start_a();
        run_a(16'h00FF, 1'b0, cyc);
        for (int i = 0; i < 10; i++) begin
            a_start = (i == 3 || i == 6);
            @(negedge clock);
            check("stall_out_valid", 32'(a_out_valid), 32'd1);
            check("stall_result", 32'(a_result), 32'(A_HALF));
            check("stall_no_restart", 32'(a_in_ready), 32'd0);
            tick();
        end
        a_out_ready = 1'b1;
        a_start     = 1'b1;
        tick();
        a_start = 1'b0;
        check("b2b_in_ready", 32'(a_in_ready), 32'd1);
        check("b2b_result_kept", 32'(a_result), 32'(A_HALF));
        exp_a_q.push_back(A_12);
        run_a(16'h0FFF, 1'b0, cyc);
        check("b2b_cycles", 32'(cyc), 32'd16);
        wait_a_idle();

        // 6: reset mid-window discards the partial count
        pulse_start_a();
        a_in_valid = 1'b1;
        a_in_bit   = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(a_in_ready), 32'd0);
        check("midrst_busy", 32'(a_busy), 32'd0);
        check("midrst_result", 32'(a_result), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("midrst_no_out_valid", 32'(a_out_valid), 32'd0);
            tick();
        end
        a_in_valid = 1'b0;
        a_in_bit   = 1'b0;

        // 3: N=12 alternating 1,0 over 4096 samples
        exp_b_q.push_back(B_ALT);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 4096; k++) begin
            b_in_valid = 1'b1;
            b_in_bit   = (k % 2 == 0);
            tick();
        end
        b_in_valid = 1'b0;
        b_in_bit   = 1'b0;
        check("b_out_valid_next", 32'(b_out_valid), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("b_return_idle", 32'(b_busy), 32'd0);

        // ---------------- final report ----------------
        for (int i = 0; i < 4; i++) tick();
        check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
